// File: rtl/ball_renderer.sv
// ball_renderer
//   Per-pixel ball hit detector. Up to N_BALLS circle descriptors are written
//   into a shadow set over an Avalon-MM slave. A commit request copies the
//   shadow set into the active set on the next VGA_VS falling edge, so a
//   frame is always drawn from one consistent set. For every DrawX/DrawY the
//   block reports is_ball/ballID two clock cycles later.
//
// Ports
//   Clk, Reset_n        system clock, asynchronous active-low reset
//   avs_chipselect      slave select (qualifies avs_read/avs_write)
//   avs_read/avs_write  read/write strobes
//   avs_address[2:0]    word address: 0..3 descriptors, 4 ctrl/status,
//                       5 frame_count, 6..7 reserved
//   avs_writedata[31:0] write data
//   avs_readdata[31:0]  registered read data (1-cycle latency)
//   VGA_VS              vertical sync, active-low, synchronous to Clk
//   DrawX, DrawY        current pixel column/row
//   is_ball             pixel lies inside an enabled active ball
//   ballID              lowest-numbered ball that contains the pixel
//   frame_tick          one-cycle pulse per VGA_VS falling edge
module ball_renderer #(
  parameter int          N_BALLS         = 4,
  parameter logic [15:0] FRAME_COUNT_RST = 16'h0000
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        avs_chipselect,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [2:0]  avs_address,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  input  logic        VGA_VS,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  output logic        is_ball,
  output logic [1:0]  ballID,
  output logic        frame_tick
);

  // Descriptor bits that exist: enable [31], radius [25:20], Y [19:10], X [9:0]
  localparam logic [31:0] DESC_MASK = 32'h83FF_FFFF;

  // |a - b| through an 11-bit signed difference; the magnitude always fits
  // in 10 bits, so centres near either screen edge need no clipping.
  function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
    logic signed [10:0] d;
    logic signed [10:0] n;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    n = -d;
    abs_diff = d[10] ? n[9:0] : d[9:0];
  endfunction

  function automatic logic [11:0] square6(input logic [5:0] r);
    logic [11:0] re;
    re = {6'd0, r};
    square6 = re * re;
  endfunction

  function automatic logic [20:0] dist_sq(input logic [9:0] dx, input logic [9:0] dy);
    logic [19:0] xe;
    logic [19:0] ye;
    xe = {10'd0, dx};
    ye = {10'd0, dy};
    dist_sq = {1'b0, xe * xe} + {1'b0, ye * ye};
  endfunction

  logic [31:0]        shadow     [N_BALLS];
  logic [9:0]         act_x      [N_BALLS];
  logic [9:0]         act_y      [N_BALLS];
  logic [5:0]         act_r      [N_BALLS];
  logic [N_BALLS-1:0] act_en;

  logic        vs_q;
  logic        vs_fall;
  logic        commit_pending;
  logic [15:0] frame_count;
  logic        wr_en;
  logic        rd_en;
  logic        commit_wr;
  logic [31:0] rd_mux;

  assign wr_en     = avs_chipselect & avs_write;
  assign rd_en     = avs_chipselect & avs_read;
  assign commit_wr = wr_en & (avs_address == 3'd4) & avs_writedata[0];
  assign vs_fall   = vs_q & ~VGA_VS;

  // A commit write in the edge cycle wins over the clear, so the new request
  // stays pending for the following frame.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      vs_q           <= 1'b1;
      frame_tick     <= 1'b0;
      frame_count    <= FRAME_COUNT_RST;
      commit_pending <= 1'b0;
    end else begin
      vs_q       <= VGA_VS;
      frame_tick <= vs_fall;
      if (vs_fall)
        frame_count <= frame_count + 16'd1;
      if (commit_wr)
        commit_pending <= 1'b1;
      else if (vs_fall)
        commit_pending <= 1'b0;
    end
  end

  // The active copy reads shadow before this edge's write lands, so a
  // descriptor written in the edge cycle waits for the next commit.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int k = 0; k < N_BALLS; k++) begin
        shadow[k] <= '0;
        act_x[k]  <= '0;
        act_y[k]  <= '0;
        act_r[k]  <= '0;
      end
      act_en <= '0;
    end else begin
      for (int k = 0; k < N_BALLS; k++) begin
        if (vs_fall && commit_pending) begin
          act_x[k]  <= shadow[k][9:0];
          act_y[k]  <= shadow[k][19:10];
          act_r[k]  <= shadow[k][25:20];
          act_en[k] <= shadow[k][31];
        end
        if (wr_en && avs_address == 3'(k))
          shadow[k] <= avs_writedata & DESC_MASK;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (avs_address)
      3'd4:    rd_mux = {frame_count, 15'd0, commit_pending};
      3'd5:    rd_mux = {16'd0, frame_count};
      default: begin
        for (int k = 0; k < N_BALLS; k++)
          if (avs_address == 3'(k))
            rd_mux = shadow[k];
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)
      avs_readdata <= '0;
    else if (rd_en)
      avs_readdata <= rd_mux;
  end

  // ---- stage 1: per-ball distances and squared radius ----
  logic [9:0]         adx_p1 [N_BALLS];
  logic [9:0]         ady_p1 [N_BALLS];
  logic [11:0]        rsq_p1 [N_BALLS];
  logic [N_BALLS-1:0] en_p1;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int k = 0; k < N_BALLS; k++) begin
        adx_p1[k] <= '0;
        ady_p1[k] <= '0;
        rsq_p1[k] <= '0;
      end
      en_p1 <= '0;
    end else begin
      for (int k = 0; k < N_BALLS; k++) begin
        adx_p1[k] <= abs_diff(DrawX, act_x[k]);
        ady_p1[k] <= abs_diff(DrawY, act_y[k]);
        rsq_p1[k] <= square6(act_r[k]);
        en_p1[k]  <= act_en[k];
      end
    end
  end

  // ---- stage 2: inclusive circle test and priority encode ----
  logic [N_BALLS-1:0] hit_s2;
  logic [1:0]         id_s2;

  always_comb begin
    hit_s2 = '0;
    id_s2  = 2'd0;
    for (int k = 0; k < N_BALLS; k++)
      hit_s2[k] = en_p1[k] && (dist_sq(adx_p1[k], ady_p1[k]) <= {9'd0, rsq_p1[k]});
    for (int k = N_BALLS - 1; k >= 0; k--)
      if (hit_s2[k])
        id_s2 = 2'(k);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      is_ball <= 1'b0;
      ballID  <= 2'd0;
    end else begin
      is_ball <= |hit_s2;
      ballID  <= id_s2;
    end
  end

endmodule
